// File: rtl/bram_arb_pkg.sv
// Shared encodings for the BRAM port-B arbiter: FSM states and read-return tags.
package bram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VID  = 2'd1,
        TAG_IO   = 2'd2
    } tag_e;

    typedef struct packed {
        tag_e tag;
        logic last;
    } rd_tag_t;

    localparam rd_tag_t RD_TAG_IDLE = '{tag: TAG_NONE, last: 1'b0};

endpackage

// File: rtl/bram_rd_tag_pipe.sv
// Two-stage tag delay matching the port-B read latency (address register + BRAM register).
module bram_rd_tag_pipe
    import bram_arb_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t tag_p0_q;
    rd_tag_t tag_p1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_p0_q <= RD_TAG_IDLE;
            tag_p1_q <= RD_TAG_IDLE;
        end else begin
            tag_p0_q <= tag_i;
            tag_p1_q <= tag_p0_q;
        end
    end

    assign tag_o = tag_p1_q;

endmodule

// File: rtl/bram_portb_arbiter.sv
// Shares BRAM port B between a prioritised video burst reader and a single-word I/O
// requester; a starvation counter forces an I/O slot after STARVE_MAX blocked video beats.
module bram_portb_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int BURST_LEN  = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_start,
    input  logic [ADDR_W-1:0] vid_base,
    output logic              vid_busy,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_done,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_gnt,
    output logic              io_rvalid,
    output logic [DATA_W-1:0] io_rdata,
    output logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] data_b,
    output logic              we_b,
    input  logic [DATA_W-1:0] q_b
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int SW    = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BURST_LEN - 1);
    localparam logic [SW-1:0]    STARVE_TOP = SW'(STARVE_MAX);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              we_q, we_d;
    logic              vid_issue;
    rd_tag_t           tag_in, tag_out;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        base_d    = base_q;
        starve_d  = starve_q;
        addr_d    = addr_q;
        data_d    = data_q;
        we_d      = 1'b0;
        io_gnt    = 1'b0;
        vid_issue = 1'b0;
        tag_in    = RD_TAG_IDLE;

        unique case (state_q)
            ST_IDLE: begin
                io_gnt = io_req;
                if (vid_start) begin
                    state_d = ST_BURST;
                    base_d  = vid_base;
                    beat_d  = '0;
                end
            end
            ST_BURST: begin
                io_gnt    = io_req && (starve_q == STARVE_TOP);
                vid_issue = !io_gnt;
                if (vid_issue) begin
                    addr_d      = base_q + ADDR_W'(beat_q);
                    tag_in.tag  = TAG_VID;
                    tag_in.last = (beat_q == LAST_BEAT);
                    if (beat_q == LAST_BEAT) state_d = ST_DRAIN;
                    else                     beat_d  = beat_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                io_gnt = io_req;
                if (vid_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (io_gnt) begin
            addr_d     = io_addr;
            data_d     = io_wdata;
            we_d       = io_we;
            tag_in.tag = io_we ? TAG_NONE : TAG_IO;
        end

        // Only beats that actually hold off a waiting requester count toward starvation.
        if (!io_req || io_gnt)                          starve_d = '0;
        else if (vid_issue && starve_q != STARVE_TOP)   starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            base_q   <= '0;
            starve_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            base_q   <= base_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            we_q     <= we_d;
        end
    end

    bram_rd_tag_pipe u_tag_pipe (
        .clk   (clk),
        .rst_n (reset),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    assign addr_b     = addr_q;
    assign data_b     = data_q;
    assign we_b       = we_q;
    assign vid_busy   = (state_q != ST_IDLE);
    assign vid_rvalid = (tag_out.tag == TAG_VID);
    assign vid_done   = vid_rvalid && tag_out.last;
    assign io_rvalid  = (tag_out.tag == TAG_IO);
    assign vid_rdata  = vid_rvalid ? q_b : '0;
    assign io_rdata   = io_rvalid  ? q_b : '0;

endmodule

// File: tb/tb_bram_portb_arbiter.sv
// Randomised and directed bench for bram_portb_arbiter with a BRAM model and a queue-based reference.
module tb_bram_portb_arbiter;

    localparam int BURST_LEN  = 8;
    localparam int STARVE_MAX = 4;

    logic        clk;
    logic        reset;
    logic        vid_start;
    logic [15:0] vid_base;
    logic        vid_busy;
    logic        vid_rvalid;
    logic [15:0] vid_rdata;
    logic        vid_done;
    logic        io_req;
    logic        io_we;
    logic [15:0] io_addr;
    logic [15:0] io_wdata;
    logic        io_gnt;
    logic        io_rvalid;
    logic [15:0] io_rdata;
    logic [15:0] addr_b;
    logic [15:0] data_b;
    logic        we_b;
    logic [15:0] q_b;

    bram_portb_arbiter #(
        .ADDR_W     (16),
        .DATA_W     (16),
        .BURST_LEN  (BURST_LEN),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .vid_start  (vid_start),
        .vid_base   (vid_base),
        .vid_busy   (vid_busy),
        .vid_rvalid (vid_rvalid),
        .vid_rdata  (vid_rdata),
        .vid_done   (vid_done),
        .io_req     (io_req),
        .io_we      (io_we),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_gnt     (io_gnt),
        .io_rvalid  (io_rvalid),
        .io_rdata   (io_rdata),
        .addr_b     (addr_b),
        .data_b     (data_b),
        .we_b       (we_b),
        .q_b        (q_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Power-on memory contents: 0x0100..0x0107 hold 0..7, everything else a fixed scramble.
    function automatic logic [15:0] init_val(input logic [15:0] a);
        if (a >= 16'h0100 && a < 16'h0108) return a - 16'h0100;
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    // BRAM port B model: one-edge read latency, read-before-write.
    logic [15:0] mem [0:65535];
    logic        wrt [0:65535];
    always @(posedge clk) begin
        if (we_b) begin
            mem[addr_b] <= data_b;
            wrt[addr_b] <= 1'b1;
        end
        q_b <= (wrt[addr_b] === 1'b1) ? mem[addr_b] : init_val(addr_b);
    end

    // Reference model state
    logic [15:0] ref_wr [logic [15:0]];
    logic [16:0] vq [$];
    logic [15:0] io_dq [$];
    int          io_cq [$];
    bit          model_busy = 1'b0;
    int          cyc = 0;
    int          io_wait = 0;
    int          start_cyc = 0;
    int          first_vid_cyc = 0;
    int          done_cyc = 0;
    int          io_rv_cyc = 0;
    int          beat_seen = 0;
    logic [15:0] last_io_rdata = '0;

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        if (ref_wr.exists(a)) return ref_wr[a];
        return init_val(a);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [16:0] e;
        bit          busy_now;
        if (!reset) begin
            vq.delete();
            io_dq.delete();
            io_cq.delete();
            model_busy = 1'b0;
            io_wait    = 0;
            chk("rst_flags", 32'({vid_busy, vid_rvalid, vid_done, io_rvalid, we_b}), 32'd0);
            chk("rst_addr_b", 32'(addr_b), 32'd0);
            chk("rst_data_b", 32'(data_b), 32'd0);
            chk("rst_rdata", 32'({vid_rdata, io_rdata}), 32'd0);
        end else begin
            busy_now = model_busy;
            chk("vid_busy", 32'(vid_busy), 32'(model_busy));
            if (vid_rvalid) begin
                if (vq.size() == 0) begin
                    chk("vid_extra_rvalid", 32'd1, 32'd0);
                end else begin
                    e = vq.pop_front();
                    chk("vid_rdata", 32'(vid_rdata), 32'(e[15:0]));
                    chk("vid_done", 32'(vid_done), 32'(e[16]));
                    if (beat_seen == 0) first_vid_cyc = cyc;
                    beat_seen++;
                    if (e[16]) begin
                        done_cyc   = cyc;
                        model_busy = 1'b0;
                    end
                end
            end
            if (io_rvalid) begin
                if (io_dq.size() == 0) begin
                    chk("io_extra_rvalid", 32'd1, 32'd0);
                end else begin
                    chk("io_rdata", 32'(io_rdata), 32'(io_dq.pop_front()));
                    chk("io_latency", 32'(cyc), 32'(io_cq.pop_front()));
                    io_rv_cyc     = cyc;
                    last_io_rdata = io_rdata;
                end
            end
            if (io_req && io_gnt) begin
                chk("io_wait_bound", 32'(io_wait <= STARVE_MAX), 32'd1);
                io_wait = 0;
                if (io_we) ref_wr[io_addr] = io_wdata;
                else begin
                    io_dq.push_back(ref_rd(io_addr));
                    io_cq.push_back(cyc + 2);
                end
            end else if (io_req) begin
                io_wait++;
            end else begin
                io_wait = 0;
            end
            if (vid_start && !busy_now) begin
                model_busy = 1'b1;
                start_cyc  = cyc;
                beat_seen  = 0;
                for (int i = 0; i < BURST_LEN; i++)
                    vq.push_back({(i == BURST_LEN - 1), ref_rd(vid_base + 16'(i))});
            end
        end
    end

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_vid(input logic [15:0] b);
        vid_start = 1'b1;
        vid_base  = b;
        @(posedge clk);
        #1;
        vid_start = 1'b0;
    endtask

    task automatic io_op(input logic we, input logic [15:0] a, input logic [15:0] d, output int waits);
        io_req   = 1'b1;
        io_we    = we;
        io_addr  = a;
        io_wdata = d;
        waits    = 0;
        @(negedge clk);
        while (!io_gnt && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (!io_gnt) chk("io_gnt_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        io_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while ((model_busy || vq.size() != 0 || io_dq.size() != 0) && n < 300);
        #1;
        if (n >= 300) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        int w;
        logic [15:0] ea;
        reset     = 1'b0;
        vid_start = 1'b0;
        vid_base  = '0;
        io_req    = 1'b0;
        io_we     = 1'b0;
        io_addr   = '0;
        io_wdata  = '0;

        // Reset state; grant follows request even while in reset
        @(posedge clk);
        #1;
        io_req = 1'b1;
        @(negedge clk);
        chk("rst_gnt_hi", 32'(io_gnt), 32'd1);
        @(posedge clk);
        #1;
        io_req = 1'b0;
        @(negedge clk);
        chk("rst_gnt_lo", 32'(io_gnt), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(2);

        // I/O write then read-back, both granted immediately in IDLE
        io_op(1'b1, 16'h0040, 16'hBEEF, w);
        chk("wr_gnt_wait", 32'(w), 32'd0);
        io_op(1'b0, 16'h0040, 16'h0000, w);
        chk("rd_gnt_wait", 32'(w), 32'd0);
        idle(3);
        chk("rd_beef", 32'(last_io_rdata), 32'hBEEF);

        // Plain burst from 0x0100 with an ignored restart pulse mid-burst
        start_vid(16'h0100);
        idle(2);
        start_vid(16'h3000);
        wait_idle();
        chk("burst_first_lat", 32'(first_vid_cyc - start_cyc), 32'd3);
        chk("burst_span", 32'(done_cyc - first_vid_cyc), 32'(BURST_LEN - 1));
        chk("burst_beats", 32'(beat_seen), 32'(BURST_LEN));

        // I/O held from burst start: forced slot after STARVE_MAX beats
        start_vid(16'h0100);
        io_op(1'b0, 16'h0040, 16'h0000, w);
        chk("starve_wait", 32'(w), 32'(STARVE_MAX));
        wait_idle();
        chk("starve_io_slot", 32'(io_rv_cyc - first_vid_cyc), 32'(STARVE_MAX));
        chk("starve_span", 32'(done_cyc - first_vid_cyc), 32'(BURST_LEN));
        chk("starve_io_data", 32'(last_io_rdata), 32'hBEEF);

        // Address wrap at the top of the address space
        start_vid(16'hFFFE);
        @(negedge clk);
        for (int i = 0; i < BURST_LEN; i++) begin
            @(negedge clk);
            ea = 16'hFFFE + 16'(i);
            chk("wrap_addr", 32'(addr_b), 32'(ea));
            chk("wrap_we", 32'(we_b), 32'd0);
        end
        wait_idle();

        // Simultaneous start and I/O write in IDLE
        vid_start = 1'b1;
        vid_base  = 16'h2200;
        io_req    = 1'b1;
        io_we     = 1'b1;
        io_addr   = 16'h0080;
        io_wdata  = 16'h1234;
        @(negedge clk);
        chk("start_with_io_gnt", 32'(io_gnt), 32'd1);
        @(posedge clk);
        #1;
        vid_start = 1'b0;
        io_req    = 1'b0;
        wait_idle();
        io_op(1'b0, 16'h0080, 16'h0000, w);
        idle(3);
        chk("start_with_io_rd", 32'(last_io_rdata), 32'h1234);

        // Reset after three issued beats aborts the burst
        start_vid(16'h2000);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_beats_seen", 32'(beat_seen), 32'd1);
        idle(2);
        reset = 1'b1;
        idle(6);
        start_vid(16'h0100);
        wait_idle();
        chk("post_rst_beats", 32'(beat_seen), 32'(BURST_LEN));

        // Random mix of bursts and I/O traffic
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0:       start_vid(16'h1000 + 16'($urandom_range(0, 16'h6FF0)));
                1, 2:    io_op(1'($urandom_range(0, 1)), 16'($urandom_range(16'h40, 16'hFF)),
                               16'($urandom), w);
                default: idle($urandom_range(1, 4));
            endcase
        end
        wait_idle();
        idle(3);
        chk("end_vid_queue", 32'(vq.size()), 32'd0);
        chk("end_io_queue", 32'(io_dq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
